// File: rtl/axis_value_source.sv
// Periodic sampler: captures a parallel value every P cycles and presents it as an
// AXI4-Stream master with tlast framing and a saturating count of dropped samples.
module axis_value_source #(
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int CNTR_WIDTH       = 32
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic [AXIS_TDATA_WIDTH-1:0] data,
  input  logic                        enable,
  input  logic [CNTR_WIDTH-1:0]       cfg_period,
  input  logic [CNTR_WIDTH-1:0]       cfg_length,
  output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic                        m_axis_tvalid,
  input  logic                        m_axis_tready,
  output logic                        m_axis_tlast,
  output logic [CNTR_WIDTH-1:0]       dropped
);

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_t;

  slot_state_t state_q;
  slot_state_t state_d;

  logic [CNTR_WIDTH-1:0] pcnt;
  logic [CNTR_WIDTH-1:0] widx;
  logic [CNTR_WIDTH-1:0] period_last;
  logic [CNTR_WIDTH-1:0] length_last;
  logic                  tick;
  logic                  load;
  logic                  drop;
  logic                  word_last;

  // Period 0/1 and length 0/1 both collapse to a terminal value of zero.
  always_comb begin
    period_last = (cfg_period == '0) ? '0 : cfg_period - CNTR_WIDTH'(1);
    length_last = (cfg_length == '0) ? '0 : cfg_length - CNTR_WIDTH'(1);
    tick        = enable && (pcnt == period_last);
    load        = tick && ((state_q == SLOT_EMPTY) || m_axis_tready);
    drop        = tick && !load;
    word_last   = (widx >= length_last);
  end

  // Using >= on wrap also recovers from a period that shrank below the current count.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      pcnt <= '0;
    end else if (!enable || (pcnt >= period_last)) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + CNTR_WIDTH'(1);
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q <= SLOT_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (load) begin
      state_d = SLOT_FULL;
    end else if ((state_q == SLOT_FULL) && m_axis_tready) begin
      state_d = SLOT_EMPTY;
    end
  end

  always_comb begin
    m_axis_tvalid = (state_q == SLOT_FULL);
  end

  // Payload and packet position only move on a load; drops leave them untouched.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      m_axis_tdata <= '0;
      m_axis_tlast <= 1'b0;
      widx         <= '0;
    end else if (load) begin
      m_axis_tdata <= data;
      m_axis_tlast <= word_last;
      widx         <= word_last ? '0 : widx + CNTR_WIDTH'(1);
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      dropped <= '0;
    end else if (drop && (dropped != '1)) begin
      dropped <= dropped + CNTR_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_axis_value_source.sv
// Directed bench for axis_value_source: table of per-cycle vectors plus
// hand-written sequences for back-pressure, saturation, enable and reset corners.
module tb_axis_value_source;

  localparam int DW = 16;
  localparam int CW = 4;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic [DW-1:0] data = '0;
  logic          enable = 1'b0;
  logic [CW-1:0] cfg_period = '0;
  logic [CW-1:0] cfg_length = '0;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready = 1'b0;
  logic          m_axis_tlast;
  logic [CW-1:0] dropped;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic          rst;
    logic          ena;
    logic [CW-1:0] per;
    logic [CW-1:0] len;
    logic          rdy;
    logic [DW-1:0] dat;
    logic          ev;
    logic [DW-1:0] ed;
    logic          el;
    logic [CW-1:0] edrp;
  } vec_t;

  vec_t vecs[$];

  axis_value_source #(
    .AXIS_TDATA_WIDTH(DW),
    .CNTR_WIDTH(CW)
  ) dut (
    .aclk(aclk),
    .aresetn(aresetn),
    .data(data),
    .enable(enable),
    .cfg_period(cfg_period),
    .cfg_length(cfg_length),
    .m_axis_tdata(m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast),
    .dropped(dropped)
  );

  always #5 aclk = ~aclk;

  task automatic stepClock();
    @(posedge aclk);
    #1;
  endtask

  task automatic applyStimulus(input logic en, input logic [CW-1:0] per, input logic [CW-1:0] len,
                               input logic rdy, input logic [DW-1:0] d);
    enable        = en;
    cfg_period    = per;
    cfg_length    = len;
    m_axis_tready = rdy;
    data          = d;
    stepClock();
  endtask

  task automatic checkValue(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic checkOutput(input string name, input logic ev, input logic [DW-1:0] ed,
                             input logic el, input logic [CW-1:0] edrp);
    checkValue({name, ".tvalid"}, int'(m_axis_tvalid), int'(ev));
    checkValue({name, ".dropped"}, int'(dropped), int'(edrp));
    if (ev) begin
      checkValue({name, ".tdata"}, int'(m_axis_tdata), int'(ed));
      checkValue({name, ".tlast"}, int'(m_axis_tlast), int'(el));
    end
  endtask

  task automatic doReset();
    aresetn       = 1'b0;
    enable        = 1'b0;
    m_axis_tready = 1'b0;
    data          = '0;
    stepClock();
    stepClock();
    checkValue("reset.tvalid", int'(m_axis_tvalid), 0);
    checkValue("reset.tlast", int'(m_axis_tlast), 0);
    checkValue("reset.tdata", int'(m_axis_tdata), 0);
    checkValue("reset.dropped", int'(dropped), 0);
    aresetn = 1'b1;
  endtask

  function automatic vec_t mkVec(input logic rst, input logic ena, input int per, input int len,
                                 input logic rdy, input int dat, input logic ev, input int ed,
                                 input logic el, input int edrp);
    vec_t v;
    v.rst  = rst;
    v.ena  = ena;
    v.per  = CW'(per);
    v.len  = CW'(len);
    v.rdy  = rdy;
    v.dat  = DW'(dat);
    v.ev   = ev;
    v.ed   = DW'(ed);
    v.el   = el;
    v.edrp = CW'(edrp);
    return v;
  endfunction

  initial begin
    // P=4, L=3, data = cycle index: words at cycles 4,8,12 carrying 3,7,11, third one last.
    for (int k = 0; k <= 12; k++) begin
      vecs.push_back(mkVec(k == 0, 1'b1, 4, 3, 1'b1, k,
                           (k == 3) || (k == 7) || (k == 11), k, k == 11, 0));
    end
    // Full rate: period 0, length 1, every cycle a single-word packet.
    for (int k = 0; k < 6; k++) begin
      vecs.push_back(mkVec(k == 0, 1'b1, 0, 1, 1'b1, 100 + k, 1'b1, 100 + k, 1'b1, 0));
    end

    foreach (vecs[i]) begin
      if (vecs[i].rst) doReset();
      applyStimulus(vecs[i].ena, vecs[i].per, vecs[i].len, vecs[i].rdy, vecs[i].dat);
      checkOutput($sformatf("vec%0d", i), vecs[i].ev, vecs[i].ed, vecs[i].el, vecs[i].edrp);
    end

    // Back-pressure: first sample held through nine drops, then packet resumes at word 1.
    doReset();
    applyStimulus(1'b1, 1, 4, 1'b0, 50);
    checkOutput("bp_load", 1'b1, 50, 1'b0, 0);
    for (int k = 1; k <= 9; k++) begin
      applyStimulus(1'b1, 1, 4, 1'b0, DW'(50 + k));
      checkOutput("bp_stall", 1'b1, 50, 1'b0, CW'(k));
    end
    applyStimulus(1'b1, 1, 4, 1'b1, 60);
    checkOutput("bp_w1", 1'b1, 60, 1'b0, 9);
    applyStimulus(1'b1, 1, 4, 1'b1, 61);
    checkOutput("bp_w2", 1'b1, 61, 1'b0, 9);
    applyStimulus(1'b1, 1, 4, 1'b1, 62);
    checkOutput("bp_w3", 1'b1, 62, 1'b1, 9);

    // Saturation: 39 drops on a 4-bit counter must stop at 15.
    doReset();
    applyStimulus(1'b1, 1, 1, 1'b0, 70);
    checkOutput("sat_load", 1'b1, 70, 1'b1, 0);
    for (int k = 1; k <= 39; k++) begin
      applyStimulus(1'b1, 1, 1, 1'b0, DW'(70 + k));
      if (k == 14) checkOutput("sat_14", 1'b1, 70, 1'b1, 14);
    end
    checkOutput("sat_end", 1'b1, 70, 1'b1, 15);

    // Enable dropped mid-packet: pending word drains, packet resumes at word 2.
    doReset();
    applyStimulus(1'b1, 1, 4, 1'b0, 200);
    checkOutput("en_w0", 1'b1, 200, 1'b0, 0);
    applyStimulus(1'b1, 1, 4, 1'b1, 201);
    checkOutput("en_w1", 1'b1, 201, 1'b0, 0);
    applyStimulus(1'b0, 1, 4, 1'b0, 202);
    checkOutput("en_hold", 1'b1, 201, 1'b0, 0);
    applyStimulus(1'b0, 1, 4, 1'b1, 203);
    checkOutput("en_drain", 1'b0, 0, 1'b0, 0);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b0, 1, 4, 1'b1, 204);
      checkOutput("en_idle", 1'b0, 0, 1'b0, 0);
    end
    applyStimulus(1'b1, 1, 4, 1'b1, 210);
    checkOutput("en_w2", 1'b1, 210, 1'b0, 0);
    applyStimulus(1'b1, 1, 4, 1'b1, 211);
    checkOutput("en_w3", 1'b1, 211, 1'b1, 0);

    // Reset while a word is stalled: widx must restart at 0 afterwards.
    doReset();
    applyStimulus(1'b1, 1, 2, 1'b1, 300);
    checkOutput("rst_w0", 1'b1, 300, 1'b0, 0);
    applyStimulus(1'b1, 1, 2, 1'b0, 301);
    checkOutput("rst_stall", 1'b1, 300, 1'b0, 1);
    aresetn = 1'b0;
    applyStimulus(1'b1, 1, 2, 1'b0, 302);
    checkOutput("rst_mid", 1'b0, 0, 1'b0, 0);
    checkValue("rst_mid.tlast", int'(m_axis_tlast), 0);
    checkValue("rst_mid.tdata", int'(m_axis_tdata), 0);
    aresetn = 1'b1;
    applyStimulus(1'b1, 1, 2, 1'b1, 310);
    checkOutput("rst_p0", 1'b1, 310, 1'b0, 0);
    applyStimulus(1'b1, 1, 2, 1'b1, 311);
    checkOutput("rst_p1", 1'b1, 311, 1'b1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
